// File: rtl/prio_encoder_q.sv
// prio_encoder_q: latches request pulses into a pending register and hands out
// one pending line index per valid/ready transfer, in fixed-priority or
// round-robin order.
//
// Parameters
//   N      number of request lines (2..64)
//   IDX_W  index width, ceil(log2(N))
//   RR     0 = fixed priority (highest index wins), 1 = round-robin
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous reset, active-high
//   req_in     request pulses, one bit per line
//   out_idx    granted line index (meaningful while out_valid=1)
//   out_valid  out_idx holds an undelivered grant
//   out_ready  consumer accepts out_idx this cycle
//   pending    pending register, bit i = line i waiting for a grant
//   overflow   sticky: a request hit a line that was already pending
module prio_encoder_q #(
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = 3,
   parameter int unsigned RR    = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_in,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     pending,
   output logic             overflow
);

   // Lowest set index of a vector (0 when empty).
   function automatic logic [IDX_W-1:0] f_lowest(input logic [N-1:0] v);
      f_lowest = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) f_lowest = IDX_W'(i);
      end
   endfunction

   // Highest set index of a vector (0 when empty).
   function automatic logic [IDX_W-1:0] f_highest(input logic [N-1:0] v);
      f_highest = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) f_highest = IDX_W'(i);
      end
   endfunction

   logic [N-1:0]     r_pending;
   logic [IDX_W-1:0] r_out_idx;
   logic             r_out_valid;
   logic             r_overflow;
   logic [IDX_W-1:0] r_rr_ptr;

   logic             w_free;
   logic             w_grant;
   logic [N-1:0]     w_above;
   logic [IDX_W-1:0] w_sel_fp;
   logic [IDX_W-1:0] w_sel_rr;
   logic [IDX_W-1:0] w_sel;
   logic [N-1:0]     w_clr;
   logic             w_ovf_hit;

   // Output slot is free when empty or being consumed this cycle.
   assign w_free  = !r_out_valid || out_ready;
   assign w_grant = w_free && (r_pending != '0);

   // Lines strictly above the round-robin pointer, searched first.
   always_comb begin
      w_above = '0;
      for (int i = 0; i < N; i++) begin
         w_above[i] = r_pending[i] && (IDX_W'(i) > r_rr_ptr);
      end
   end

   assign w_sel_fp = f_highest(r_pending);
   // Round-robin: first set bit above the pointer, else wrap to the lowest.
   assign w_sel_rr = (w_above != '0) ? f_lowest(w_above) : f_lowest(r_pending);
   assign w_sel    = (RR != 0) ? w_sel_rr : w_sel_fp;

   assign w_clr     = w_grant ? (N'(1) << w_sel) : '0;
   // A new request on a line that stays pending is lost.
   assign w_ovf_hit = |(req_in & r_pending & ~w_clr);

   // State update; requests are ORed in after the grant clear (set beats clear).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending   <= '0;
         r_out_idx   <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_rr_ptr    <= IDX_W'(N - 1);
      end else begin
         r_pending <= (r_pending & ~w_clr) | req_in;
         if (w_ovf_hit) r_overflow <= 1'b1;
         if (w_free) begin
            r_out_valid <= w_grant;
            if (w_grant) begin
               r_out_idx <= w_sel;
               if (RR != 0) r_rr_ptr <= w_sel;
            end
         end
      end
   end

   assign out_idx   = r_out_idx;
   assign out_valid = r_out_valid;
   assign pending   = r_pending;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Bench for prio_encoder_q: one fixed-priority and one round-robin instance
// share stimulus; a per-instance model predicts grants into a queue that is
// consumed on each transfer, plus directed checks from the test plan.
module tb_prio_encoder_q;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req_in;
   logic       out_ready;

   logic [2:0] fp_idx, rr_idx;
   logic       fp_valid, rr_valid;
   logic [7:0] fp_pend, rr_pend;
   logic       fp_ovf, rr_ovf;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   prio_encoder_q #(.N(8), .IDX_W(3), .RR(0)) u_fp (
      .clk(clk), .rst(rst), .req_in(req_in), .out_idx(fp_idx),
      .out_valid(fp_valid), .out_ready(out_ready), .pending(fp_pend),
      .overflow(fp_ovf)
   );

   prio_encoder_q #(.N(8), .IDX_W(3), .RR(1)) u_rr (
      .clk(clk), .rst(rst), .req_in(req_in), .out_idx(rr_idx),
      .out_valid(rr_valid), .out_ready(out_ready), .pending(rr_pend),
      .overflow(rr_ovf)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state; index 0 = fixed priority, 1 = round-robin.
   logic [7:0] m_pend [2];
   logic       m_ovf  [2];
   int         m_ptr  [2];
   int         q_fp[$];
   int         q_rr[$];

   function automatic int pick(input int d, input logic [7:0] p, input int ptr);
      pick = -1;
      if (d == 0) begin
         for (int i = 7; i >= 0; i--) if (pick < 0 && p[i]) pick = i;
      end else begin
         for (int k = 1; k <= 8; k++) if (pick < 0 && p[(ptr + k) % 8]) pick = (ptr + k) % 8;
      end
   endfunction

   task automatic model_edge(input int d);
      int         sz;
      int         g;
      bit         free;
      logic [7:0] clr;
      if (rst) begin
         m_pend[d] = '0;
         m_ovf[d]  = 1'b0;
         m_ptr[d]  = 7;
         if (d == 0) q_fp.delete(); else q_rr.delete();
      end else begin
         sz   = (d == 0) ? q_fp.size() : q_rr.size();
         free = (sz == 0) || out_ready;
         if (sz > 0 && out_ready) begin
            if (d == 0) void'(q_fp.pop_front()); else void'(q_rr.pop_front());
         end
         clr = '0;
         if (free && m_pend[d] != 0) begin
            g = pick(d, m_pend[d], m_ptr[d]);
            if (d == 0) q_fp.push_back(g); else q_rr.push_back(g);
            clr[g] = 1'b1;
            if (d == 1) m_ptr[d] = g;
         end
         if ((req_in & m_pend[d] & ~clr) != 0) m_ovf[d] = 1'b1;
         m_pend[d] = (m_pend[d] & ~clr) | req_in;
      end
   endtask

   always @(posedge clk) begin
      model_edge(0);
      model_edge(1);
   end

   task automatic check_all();
      chk("fp_valid", 64'(fp_valid), 64'(q_fp.size() != 0));
      if (q_fp.size() != 0) chk("fp_idx", 64'(fp_idx), 64'(q_fp[0]));
      chk("fp_pend", 64'(fp_pend), 64'(m_pend[0]));
      chk("fp_ovf", 64'(fp_ovf), 64'(m_ovf[0]));
      chk("rr_valid", 64'(rr_valid), 64'(q_rr.size() != 0));
      if (q_rr.size() != 0) chk("rr_idx", 64'(rr_idx), 64'(q_rr[0]));
      chk("rr_pend", 64'(rr_pend), 64'(m_pend[1]));
      chk("rr_ovf", 64'(rr_ovf), 64'(m_ovf[1]));
   endtask

   task automatic step(input logic [7:0] r, input logic rd);
      req_in    = r;
      out_ready = rd;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_rst(input int n);
      rst = 1'b1;
      repeat (n) step(8'h00, 1'b1);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req_in    = '0;
      out_ready = 1'b1;

      // Reset and single request: grant of 4 two cycles after the pulse.
      do_rst(2);
      chk("rst_valid", 64'(fp_valid), 64'd0);
      chk("rst_idx", 64'(fp_idx), 64'd0);
      chk("rst_pend", 64'(fp_pend), 64'd0);
      step(8'h10, 1'b1);
      chk("lat1_valid", 64'(fp_valid), 64'd0);
      chk("lat1_pend", 64'(fp_pend), 64'h10);
      step(8'h00, 1'b1);
      chk("lat2_valid", 64'(fp_valid), 64'd1);
      chk("lat2_idx", 64'(fp_idx), 64'd4);
      chk("lat2_rr_idx", 64'(rr_idx), 64'd4);
      step(8'h00, 1'b1);
      chk("lat3_valid", 64'(fp_valid), 64'd0);
      chk("lat3_pend", 64'(fp_pend), 64'd0);
      chk("lat3_ovf", 64'(fp_ovf), 64'd0);

      // Fixed priority drain of 8'hA5: 7,5,2,0.
      step(8'hA5, 1'b1);
      step(8'h00, 1'b1); chk("drain_7", 64'(fp_idx), 64'd7);
      step(8'h00, 1'b1); chk("drain_5", 64'(fp_idx), 64'd5);
      step(8'h00, 1'b1); chk("drain_2", 64'(fp_idx), 64'd2);
      step(8'h00, 1'b1); chk("drain_0", 64'(fp_idx), 64'd0);
      chk("drain_0_v", 64'(fp_valid), 64'd1);
      step(8'h00, 1'b1); chk("drain_end_v", 64'(fp_valid), 64'd0);

      // Round-robin fairness: 8'h81 every 4 cycles alternates 0,7.
      do_rst(1);
      for (int p = 0; p < 3; p++) begin
         step(8'h81, 1'b1);
         step(8'h00, 1'b1); chk("rr_alt_0", 64'(rr_idx), 64'd0);
         step(8'h00, 1'b1); chk("rr_alt_7", 64'(rr_idx), 64'd7);
         step(8'h00, 1'b1); chk("rr_alt_idle", 64'(rr_valid), 64'd0);
      end

      // Round-robin burst of 8'hFF from reset: 0..7.
      do_rst(1);
      step(8'hFF, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(8'h00, 1'b1);
         chk("rr_burst", 64'(rr_idx), 64'(i));
      end
      step(8'h00, 1'b1);
      chk("rr_burst_end", 64'(rr_valid), 64'd0);

      // Backpressure: pending 8'h0C, stalled 5 cycles, then 3 then 2.
      do_rst(1);
      step(8'h0C, 1'b0);
      step(8'h00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(8'h00, 1'b0);
         chk("bp_idx", 64'(fp_idx), 64'd3);
         chk("bp_valid", 64'(fp_valid), 64'd1);
         chk("bp_pend", 64'(fp_pend), 64'h04);
      end
      step(8'h00, 1'b1); chk("bp_rel_2", 64'(fp_idx), 64'd2);
      step(8'h00, 1'b1); chk("bp_rel_end", 64'(fp_valid), 64'd0);

      // Collision: line 2 pending while stalled, pulsed again -> sticky overflow.
      do_rst(1);
      step(8'h04, 1'b0);
      step(8'h00, 1'b0);
      step(8'h04, 1'b0);
      chk("col_no_ovf", 64'(fp_ovf), 64'd0);
      step(8'h04, 1'b0);
      chk("col_ovf", 64'(fp_ovf), 64'd1);
      for (int i = 0; i < 4; i++) step(8'h00, 1'b1);
      chk("col_sticky", 64'(fp_ovf), 64'd1);

      // Set beats clear: request 5 in the cycle 5 is granted.
      do_rst(1);
      step(8'h20, 1'b1);
      step(8'h20, 1'b1);
      chk("sbc_idx", 64'(fp_idx), 64'd5);
      chk("sbc_pend", 64'(fp_pend), 64'h20);
      chk("sbc_ovf", 64'(fp_ovf), 64'd0);
      step(8'h00, 1'b1);
      chk("sbc_regrant", 64'(fp_idx), 64'd5);
      chk("sbc_regrant_v", 64'(fp_valid), 64'd1);
      step(8'h00, 1'b1);
      chk("sbc_done", 64'(fp_valid), 64'd0);

      // Reset mid-operation with pending=8'hF0 and a grant outstanding.
      do_rst(1);
      step(8'hF0, 1'b0);
      step(8'h00, 1'b0);
      step(8'hF0, 1'b0);
      chk("mid_pend", 64'(fp_pend), 64'hF0);
      chk("mid_valid", 64'(fp_valid), 64'd1);
      do_rst(1);
      chk("mid_rst_pend", 64'(fp_pend), 64'd0);
      chk("mid_rst_valid", 64'(fp_valid), 64'd0);
      chk("mid_rst_ovf", 64'(fp_ovf), 64'd0);
      chk("mid_rst_idx", 64'(fp_idx), 64'd0);
      chk("mid_rst_rr_idx", 64'(rr_idx), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step(8'h00, 1'b1);
         chk("mid_no_stale", 64'(fp_valid | rr_valid), 64'd0);
      end
      step(8'h02, 1'b1);
      chk("mid_first_lat", 64'(fp_valid), 64'd0);
      step(8'h00, 1'b1);
      chk("mid_first_idx", 64'(fp_idx), 64'd1);

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         step(8'($urandom_range(0, 255) & $urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
